// File: rtl/plic_claim_ctrl_pkg.sv
// plic_claim_ctrl_pkg: shared gateway state type and default PLIC sizing
package plic_claim_ctrl_pkg;
  localparam int PLIC_SOURCE_COUNT = 8;
  localparam int PLIC_SOURCE_WIDTH = 4;
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } plic_gw_state_e;
endpackage

// File: rtl/plic_claim_ctrl_if.sv
// plic_claim_ctrl_if: claim/complete strobes from the register interface and per-source status back
interface plic_claim_ctrl_if #(
  parameter int SOURCE_COUNT = plic_claim_ctrl_pkg::PLIC_SOURCE_COUNT,
  parameter int SOURCE_WIDTH = plic_claim_ctrl_pkg::PLIC_SOURCE_WIDTH
);
  logic                    claim_req_i;
  logic [SOURCE_WIDTH-1:0] claim_idx_i;
  logic                    complete_req_i;
  logic [SOURCE_WIDTH-1:0] complete_idx_i;
  logic [SOURCE_COUNT-1:0] irq_pending_o;
  logic [SOURCE_COUNT-1:0] in_service_o;
  logic [SOURCE_COUNT-1:0] edge_held_o;
  modport master (
    output claim_req_i, claim_idx_i, complete_req_i, complete_idx_i,
    input  irq_pending_o, in_service_o, edge_held_o
  );
  modport slave (
    input  claim_req_i, claim_idx_i, complete_req_i, complete_idx_i,
    output irq_pending_o, in_service_o, edge_held_o
  );
endinterface

// File: rtl/plic_claim_ctrl_gateway.sv
// plic_gateway: one source's synchroniser, edge detect, IDLE/PENDING/CLAIMED FSM and one-deep edge hold
module plic_gateway
  import plic_claim_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic edge_mode_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic pending_o,
  output logic in_service_o,
  output logic edge_held_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic s, s_prev_q, edge_det, trig;
  logic edge_held_q, edge_held_d;
  plic_gw_state_e state_q, state_d;
  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~s_prev_q;
  assign trig     = edge_mode_i ? edge_det : s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      s_prev_q    <= 1'b0;
      edge_held_q <= 1'b0;
      state_q     <= GW_IDLE;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_i};
      s_prev_q    <= s;
      edge_held_q <= edge_held_d;
      state_q     <= state_d;
    end
  end
  // triggers outside IDLE/CLAIMED are merged; only an edge in CLAIMED is remembered
  always_comb begin
    state_d     = state_q;
    edge_held_d = edge_held_q;
    case (state_q)
      GW_IDLE:    state_d = trig ? GW_PENDING : GW_IDLE;
      GW_PENDING: state_d = claim_hit_i ? GW_CLAIMED : GW_PENDING;
      GW_CLAIMED: begin
        if (complete_hit_i) begin
          state_d     = (edge_mode_i && (edge_held_q || edge_det)) ? GW_PENDING : GW_IDLE;
          edge_held_d = 1'b0;
        end else if (edge_mode_i && edge_det) begin
          edge_held_d = 1'b1;
        end
      end
      default:    state_d = GW_IDLE;
    endcase
  end
  always_comb begin
    pending_o    = state_q == GW_PENDING;
    in_service_o = state_q == GW_CLAIMED;
    edge_held_o  = edge_held_q;
  end
endmodule

// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: decodes claim/complete indices into one-hot hits and hosts one gateway per source
module plic_claim_ctrl
  import plic_claim_ctrl_pkg::*;
#(
  parameter int SOURCE_COUNT = PLIC_SOURCE_COUNT,
  parameter int SOURCE_WIDTH = PLIC_SOURCE_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SOURCE_COUNT-1:0] irq_src_i,
  input  logic [SOURCE_COUNT-1:0] regs_edge_i,
  plic_claim_ctrl_if.slave        bus
);
  logic [SOURCE_COUNT-1:0] claim_hit, complete_hit, pending, in_service, edge_held;
  // index k selects source k-1; i+1 is cast to SOURCE_WIDTH so a full 2^W-1 source map still decodes
  for (genvar i = 0; i < SOURCE_COUNT; i++) begin : g_src
    assign claim_hit[i]    = bus.claim_req_i && (bus.claim_idx_i == SOURCE_WIDTH'(i + 1));
    assign complete_hit[i] = bus.complete_req_i && (bus.complete_idx_i == SOURCE_WIDTH'(i + 1));
    plic_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_i          (irq_src_i[i]),
      .edge_mode_i    (regs_edge_i[i]),
      .claim_hit_i    (claim_hit[i]),
      .complete_hit_i (complete_hit[i]),
      .pending_o      (pending[i]),
      .in_service_o   (in_service[i]),
      .edge_held_o    (edge_held[i])
    );
  end
  assign bus.irq_pending_o = pending;
  assign bus.in_service_o  = in_service;
  assign bus.edge_held_o   = edge_held;
endmodule

// File: tb/tb_plic_claim_ctrl.sv
// tb_plic_claim_ctrl: directed stimulus pushes expected status into a scoreboard; a monitor pops and compares
module tb_plic_claim_ctrl;
  import plic_claim_ctrl_pkg::*;
  localparam int N = PLIC_SOURCE_COUNT;
  localparam int W = PLIC_SOURCE_WIDTH;
  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] s;
    logic [N-1:0] h;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] irq_src, regs_edge;
  logic [N-1:0] ep = '0, es = '0, eh = '0;
  exp_t q[$];
  string nq[$];
  exp_t e;
  string nm;
  int n_cmp = 0, n_bad = 0;
  plic_claim_ctrl_if #(.SOURCE_COUNT(N), .SOURCE_WIDTH(W)) bus ();
  plic_claim_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_src_i   (irq_src),
    .regs_edge_i (regs_edge),
    .bus         (bus)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk or negedge rst_n);
    #1;
    while (q.size() > 0) begin
      e  = q.pop_front();
      nm = nq.pop_front();
      n_cmp++;
      if ({bus.irq_pending_o, bus.in_service_o, bus.edge_held_o} !== e) begin
        n_bad++;
        $display("FAIL %s: got pend=%h serv=%h held=%h, want pend=%h serv=%h held=%h",
                 nm, bus.irq_pending_o, bus.in_service_o, bus.edge_held_o, e.p, e.s, e.h);
      end
    end
  end
  task automatic expect_now(input string n);
    q.push_back('{p: ep, s: es, h: eh});
    nq.push_back(n);
  endtask
  task automatic tick(input string n);
    @(posedge clk);
    expect_now(n);
    @(negedge clk);
    bus.claim_req_i    = 1'b0;
    bus.complete_req_i = 1'b0;
  endtask
  task automatic claim(input logic [W-1:0] idx);
    bus.claim_req_i = 1'b1;
    bus.claim_idx_i = idx;
  endtask
  task automatic complete(input logic [W-1:0] idx);
    bus.complete_req_i = 1'b1;
    bus.complete_idx_i = idx;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    irq_src            = '0;
    regs_edge          = N'(1);
    bus.claim_req_i    = 1'b0;
    bus.claim_idx_i    = '0;
    bus.complete_req_i = 1'b0;
    bus.complete_idx_i = '0;
    tick("reset");
    rst_n = 1'b1;
    irq_src[2] = 1'b1;
    tick("lvl_sync1");
    tick("lvl_sync2");
    ep[2] = 1'b1;
    tick("lvl_pend");
    claim(3); ep[2] = 1'b0; es[2] = 1'b1;
    tick("lvl_claim");
    complete(3); es[2] = 1'b0;
    tick("lvl_complete_idle");
    ep[2] = 1'b1;
    tick("lvl_repend");
    claim(3); ep[2] = 1'b0; es[2] = 1'b1;
    tick("lvl_claim2");
    irq_src[2] = 1'b0;
    tick("lvl_drop1");
    tick("lvl_drop2");
    complete(3); es[2] = 1'b0;
    tick("lvl_done");
    tick("lvl_stay_idle");
    irq_src[0] = 1'b1;
    tick("e_p1a");
    irq_src[0] = 1'b0;
    tick("e_p1b");
    ep[0] = 1'b1;
    tick("e_pend");
    claim(1); ep[0] = 1'b0; es[0] = 1'b1;
    tick("e_claim");
    irq_src[0] = 1'b1;
    tick("e_p2a");
    irq_src[0] = 1'b0;
    tick("e_p2b");
    eh[0] = 1'b1;
    tick("e_held");
    irq_src[0] = 1'b1;
    tick("e_p3a");
    irq_src[0] = 1'b0;
    tick("e_p3b");
    tick("e_held_merged");
    complete(1); ep[0] = 1'b1; es[0] = 1'b0; eh[0] = 1'b0;
    tick("e_complete_repend");
    irq_src[0] = 1'b1;
    tick("e_p4a");
    irq_src[0] = 1'b0;
    tick("e_p4b");
    tick("e_pend_merge");
    claim(1); ep[0] = 1'b0; es[0] = 1'b1;
    tick("e_merge_claim");
    tick("e_no_held");
    complete(1); es[0] = 1'b0;
    tick("e_idle");
    claim(2);
    tick("inv_claim_idle");
    irq_src[1] = 1'b1;
    tick("inv_s1");
    tick("inv_s2");
    ep[1] = 1'b1;
    tick("inv_pend");
    claim(0);
    tick("inv_claim0");
    claim(W'(N + 1));
    tick("inv_claim_oor");
    claim('1);
    tick("inv_claim_max");
    complete(2);
    tick("inv_complete_pend");
    irq_src[1] = 1'b0;
    tick("inv_d1");
    tick("inv_latched");
    irq_src[4:3] = 2'b11;
    tick("sc_s1");
    tick("sc_s2");
    ep[4:3] = 2'b11;
    tick("sc_pend");
    claim(5); ep[4] = 1'b0; es[4] = 1'b1;
    tick("sc_claim5");
    irq_src[4] = 1'b0;
    tick("sc_d1");
    tick("sc_d2");
    claim(4); complete(5); ep[3] = 1'b0; es[3] = 1'b1; es[4] = 1'b0;
    tick("sc_both");
    claim(4); complete(4); es[3] = 1'b0;
    tick("sc_same_idx");
    ep[3] = 1'b1;
    tick("sc_repend");
    irq_src[0] = 1'b1;
    tick("r_p1a");
    irq_src[0] = 1'b0;
    tick("r_p1b");
    ep[0] = 1'b1;
    tick("r_pend");
    claim(1); ep[0] = 1'b0; es[0] = 1'b1;
    tick("r_claim");
    irq_src[0] = 1'b1;
    tick("r_p2a");
    irq_src[0] = 1'b0;
    tick("r_p2b");
    eh[0] = 1'b1;
    tick("r_held");
    #2;
    irq_src = N'(4);
    ep = '0; es = '0; eh = '0;
    expect_now("r_async");
    rst_n = 1'b0;
    tick("r_hold");
    rst_n = 1'b1;
    tick("r_rel1");
    tick("r_rel2");
    ep[2] = 1'b1;
    tick("r_rel_pend");
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
